sram_bus_arbiter: RTL and testbench

Sequences monitor (cmdline) access to the shared external SRAM. The block requests the bus from the Z80 through the busrq_n/busak_n handshake. Once granted, it runs single-byte SRAM read or write cycles with fixed wait states, then returns the bus to the CPU. It sits between the cmdline interpreter and the SRAM pins, and also holds the CPU halted for the persistent halt/go commands.

---
 rtl/sram_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// Acquires the Z80 bus through busrq_n/busak_n and runs single-byte SRAM read/write
// cycles for the monitor; also keeps the CPU off the bus while hold is asserted.
module sram_bus_arbiter #(
  parameter int ADDR_W        = 17,
  parameter int WAIT_CYCLES   = 2,
  parameter int GRANT_TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              mon_req,
  input  logic              mon_we,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [7:0]        mon_wdata,
  output logic [7:0]        mon_rdata,
  output logic              mon_ack,
  output logic              mon_err,
  output logic              held,
  output logic              busrq_n,
  input  logic              busak_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_drive,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_GRANTED, S_SETUP, S_ACCESS, S_DONE, S_RELEASE
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(GRANT_TIMEOUT - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(WAIT_CYCLES - 1);

  state_t              state, state_d;
  logic [15:0]         cnt, cnt_d;
  logic                blocked, blocked_d;
  logic                op_we, op_we_d;
  logic [1:0]          busak_sync;
  logic                busak_s;
  logic [7:0]          mon_rdata_d, sram_dout_d;
  logic                mon_ack_d, mon_err_d, held_d, busrq_n_d;
  logic [ADDR_W-1:0]   sram_addr_d;
  logic                sram_drive_d, sram_ce_n_d, sram_oe_n_d, sram_we_n_d;

  // busak_n comes straight from the CPU pin, unrelated to clock
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busak_sync <= 2'b11;
    else          busak_sync <= {busak_sync[0], busak_n};
  end
  assign busak_s = busak_sync[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      blocked    <= 1'b0;
      op_we      <= 1'b0;
      mon_rdata  <= '0;
      mon_ack    <= 1'b0;
      mon_err    <= 1'b0;
      held       <= 1'b0;
      busrq_n    <= 1'b1;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      blocked    <= blocked_d;
      op_we      <= op_we_d;
      mon_rdata  <= mon_rdata_d;
      mon_ack    <= mon_ack_d;
      mon_err    <= mon_err_d;
      held       <= held_d;
      busrq_n    <= busrq_n_d;
      sram_addr  <= sram_addr_d;
      sram_dout  <= sram_dout_d;
      sram_drive <= sram_drive_d;
      sram_ce_n  <= sram_ce_n_d;
      sram_oe_n  <= sram_oe_n_d;
      sram_we_n  <= sram_we_n_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    blocked_d    = blocked;
    op_we_d      = op_we;
    mon_rdata_d  = mon_rdata;
    mon_ack_d    = 1'b0;
    mon_err_d    = 1'b0;
    held_d       = held;
    busrq_n_d    = busrq_n;
    sram_addr_d  = sram_addr;
    sram_dout_d  = sram_dout;
    sram_drive_d = sram_drive;
    sram_ce_n_d  = sram_ce_n;
    sram_oe_n_d  = sram_oe_n;
    sram_we_n_d  = sram_we_n;
    case (state)
      S_IDLE: begin
        if (!hold && !mon_req) blocked_d = 1'b0;
        if ((hold || mon_req) && !blocked) begin
          state_d   = S_REQ;
          busrq_n_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_REQ: begin
        cnt_d = cnt + 16'd1;
        if (!busak_s) begin
          state_d = S_GRANTED;
          held_d  = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          // give up; stay blocked until both requesters go quiet
          state_d   = S_IDLE;
          busrq_n_d = 1'b1;
          blocked_d = 1'b1;
          mon_err_d = 1'b1;
          mon_ack_d = mon_req;
        end
      end
      S_GRANTED: begin
        if (mon_req) begin
          state_d     = S_SETUP;
          op_we_d     = mon_we;
          sram_addr_d = mon_addr;
          sram_ce_n_d = 1'b0;
          if (mon_we) begin
            sram_dout_d  = mon_wdata;
            sram_drive_d = 1'b1;
          end
        end else if (!hold) begin
          state_d   = S_RELEASE;
          busrq_n_d = 1'b1;
          held_d    = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
        if (op_we) sram_we_n_d = 1'b0;
        else       sram_oe_n_d = 1'b0;
      end
      S_ACCESS: begin
        cnt_d = cnt + 16'd1;
        if (cnt == WAIT_LAST) begin
          state_d     = S_DONE;
          sram_oe_n_d = 1'b1;
          sram_we_n_d = 1'b1;
          mon_ack_d   = 1'b1;
          if (!op_we) mon_rdata_d = sram_din;
        end
      end
      S_DONE: begin
        // address, data and ce_n stay put one cycle past the strobe
        if (!mon_req) begin
          state_d      = S_GRANTED;
          sram_ce_n_d  = 1'b1;
          sram_drive_d = 1'b0;
        end
      end
      S_RELEASE: begin
        if (busak_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: behavioural SRAM and Z80 bus models, directed scenarios
// plus randomized read/write traffic checked against a reference memory image.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;
  localparam int AW = 17;
  localparam int WC = 2;
  localparam int GT = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          hold, mon_req, mon_we;
  logic [AW-1:0] mon_addr;
  logic [7:0]    mon_wdata, mon_rdata;
  logic          mon_ack, mon_err, held, busrq_n, busak_n;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dout;
  logic [7:0]    sram_din = 8'hEE;
  logic          sram_drive, sram_ce_n, sram_oe_n, sram_we_n;

  logic cpu_auto = 1'b0;
  logic man_ak   = 1'b1;
  logic auto_ak  = 1'b1;
  int   auto_dly = 0;
  logic mon_en   = 1'b0;
  int   checks   = 0;
  int   fails    = 0;

  logic [7:0] sram_mem [logic [16:0]];
  logic [7:0] exp_mem  [logic [16:0]];
  int         oe_age = 0;

  always #5 clock = ~clock;
  assign busak_n = cpu_auto ? auto_ak : man_ak;

  sram_bus_arbiter #(.ADDR_W(AW), .WAIT_CYCLES(WC), .GRANT_TIMEOUT(GT)) dut (
    .clock(clock), .reset_n(reset_n), .hold(hold), .mon_req(mon_req), .mon_we(mon_we),
    .mon_addr(mon_addr), .mon_wdata(mon_wdata), .mon_rdata(mon_rdata), .mon_ack(mon_ack),
    .mon_err(mon_err), .held(held), .busrq_n(busrq_n), .busak_n(busak_n),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));

  // Power-up SRAM contents; 0x1FFFF comes up as 0x5A
  function automatic logic [7:0] pat(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {a[16], 7'b0} ^ 8'hDA;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [16:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [16:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : pat(a);
  endfunction

  // Z80 that answers busrq_n after a random delay
  always @(posedge clock) begin
    if (auto_ak != busrq_n) begin
      if (auto_dly == 0) begin
        auto_ak  <= busrq_n;
        auto_dly <= $urandom_range(0, 3);
      end else begin
        auto_dly <= auto_dly - 1;
      end
    end
  end

  // SRAM with one cycle of access time: data is only valid from the second oe_n-low cycle
  always @(negedge clock) begin
    if (!sram_ce_n && !sram_we_n && sram_drive) sram_mem[sram_addr] = sram_dout;
    if (!sram_ce_n && !sram_oe_n) begin
      sram_din = (oe_age >= 1) ? mem_rd(sram_addr) : 8'hEE;
      oe_age   = oe_age + 1;
    end else begin
      sram_din = 8'hEE;
      oe_age   = 0;
    end
  end

  logic prev_ack = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clock) begin
    logic [3:0] viol;
    if (reset_n && mon_en) begin
      viol = {(!sram_oe_n || !sram_we_n) && sram_ce_n,
              !sram_oe_n && !sram_we_n,
              sram_drive && (sram_ce_n || !sram_oe_n),
              (mon_ack && prev_ack) || (mon_err && prev_err)};
      checks++;
      if (viol !== 4'b0000) begin
        fails++;
        $display("FAIL protocol: violation bits %b, required 0000 at %0t", viol, $time);
      end
    end
    prev_ack = mon_ack;
    prev_err = mon_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Issues one monitor operation; cycle counts are relative to the negedge that raised mon_req.
  task automatic do_op(input logic we, input logic [16:0] addr, input logic [7:0] wd, input int extra,
                       output logic [7:0] rd, output int ack_at, output int we_lo, output int oe_lo,
                       output logic [16:0] a_seen, output logic [7:0] d_seen, output int drv,
                       output int acks, output int bus_lo);
    int drop_at;
    drop_at = -1;
    rd = '0; ack_at = -1; we_lo = 0; oe_lo = 0; a_seen = '0; d_seen = '0;
    drv = 0; acks = 0; bus_lo = 0;
    mon_we = we; mon_addr = addr; mon_wdata = wd; mon_req = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      if (!sram_we_n) begin we_lo++; d_seen = sram_dout; end
      if (!sram_oe_n) oe_lo++;
      if (!sram_ce_n) a_seen = sram_addr;
      if (sram_drive) drv++;
      if (!busrq_n) bus_lo++;
      if (mon_ack) acks++;
      if (mon_ack && ack_at < 0) begin ack_at = k; rd = mon_rdata; drop_at = k + extra; end
      if (drop_at >= 0 && k == drop_at) mon_req = 1'b0;
      if (drop_at >= 0 && k == drop_at + 2) break;
    end
    mon_req = 1'b0;
  endtask

  task automatic wait_held(input logic val, input int bound, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clock);
      if (held === val) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    hold = 0; mon_req = 0; mon_we = 0; mon_addr = '0; mon_wdata = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busrq_n, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, held, mon_ack, mon_err} !== 8'b11110000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 11110000",
               {busrq_n, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, held, mon_ack, mon_err});
    end
    checks++;
    if ({sram_addr, sram_dout, mon_rdata} !== 33'd0) begin
      fails++;
      $display("FAIL reset_data: got addr %h dout %h rdata %h, required 0", sram_addr, sram_dout, mon_rdata);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busrq_n, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, held, mon_ack, mon_err} !== 8'b11110000) begin
      fails++;
      $display("FAIL reset_idle: got %b, required 11110000",
               {busrq_n, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, held, mon_ack, mon_err});
    end
  endtask

  task automatic test_halt_go;
    int   held_at;
    logic stayed, ok;
    cpu_auto = 0; man_ak = 1'b1;
    hold = 1'b1;
    @(negedge clock);
    checks++;
    if (busrq_n !== 1'b0) begin fails++; $display("FAIL halt_busrq: got %b, required 0", busrq_n); end
    repeat (5) @(negedge clock);
    man_ak = 1'b0;
    held_at = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (held && held_at < 0) held_at = k;
    end
    checks++;
    if (held_at < 2 || held_at > 3) begin
      fails++; $display("FAIL halt_held_latency: got %0d cycles, required 2..3", held_at);
    end
    hold = 1'b0;
    @(negedge clock);
    checks++;
    if ({busrq_n, held} !== 2'b10) begin
      fails++; $display("FAIL go_release: got busrq_n/held %b, required 10", {busrq_n, held});
    end
    // a new hold while still releasing must wait for the return to idle
    man_ak = 1'b1; hold = 1'b1;
    stayed = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (busrq_n !== 1'b1) stayed = 1'b0;
    end
    checks++;
    if (stayed !== 1'b1) begin fails++; $display("FAIL release_defer: got early busrq_n, required 1 for 3 cycles"); end
    @(negedge clock);
    checks++;
    if (busrq_n !== 1'b0) begin fails++; $display("FAIL rerequest_after_idle: got %b, required 0", busrq_n); end
    man_ak = 1'b0;
    wait_held(1'b1, 10, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL regrant: got held=%b, required 1", held); end
  endtask

  task automatic test_write;
    logic [7:0] rd, ds; logic [16:0] as; int ack_at, we_lo, oe_lo, drv, acks, bl;
    do_op(1'b1, 17'h00082, 8'h26, 3, rd, ack_at, we_lo, oe_lo, as, ds, drv, acks, bl);
    exp_mem[17'h00082] = 8'h26;
    checks++; if (as !== 17'h00082) begin fails++; $display("FAIL wr_addr: got %h, required 00082", as); end
    checks++; if (ds !== 8'h26) begin fails++; $display("FAIL wr_dout: got %h, required 26", ds); end
    checks++; if (we_lo !== WC) begin fails++; $display("FAIL wr_we_len: got %0d, required %0d", we_lo, WC); end
    checks++; if (oe_lo !== 0) begin fails++; $display("FAIL wr_oe_len: got %0d, required 0", oe_lo); end
    checks++; if (ack_at !== WC + 2) begin fails++; $display("FAIL wr_ack_cycle: got %0d, required %0d", ack_at, WC + 2); end
    checks++; if (acks !== 1) begin fails++; $display("FAIL wr_ack_count: got %0d, required 1", acks); end
    checks++; if (drv !== WC + 5) begin fails++; $display("FAIL wr_drive_len: got %0d, required %0d", drv, WC + 5); end
    checks++;
    if (mem_rd(17'h00082) !== 8'h26) begin
      fails++; $display("FAIL wr_sram_content: got %h, required 26", mem_rd(17'h00082));
    end
  endtask

  task automatic test_read;
    logic [7:0] rd, ds; logic [16:0] as; int ack_at, we_lo, oe_lo, drv, acks, bl;
    do_op(1'b0, 17'h1FFFF, 8'h00, 0, rd, ack_at, we_lo, oe_lo, as, ds, drv, acks, bl);
    checks++; if (rd !== 8'h5A) begin fails++; $display("FAIL rd_data: got %h, required 5a", rd); end
    checks++; if (oe_lo !== WC) begin fails++; $display("FAIL rd_oe_len: got %0d, required %0d", oe_lo, WC); end
    checks++; if (we_lo !== 0) begin fails++; $display("FAIL rd_we_len: got %0d, required 0", we_lo); end
    checks++; if (drv !== 0) begin fails++; $display("FAIL rd_drive: got %0d cycles, required 0", drv); end
    checks++; if (ack_at !== WC + 2) begin fails++; $display("FAIL rd_ack_cycle: got %0d, required %0d", ack_at, WC + 2); end
    checks++; if (as !== 17'h1FFFF) begin fails++; $display("FAIL rd_addr: got %h, required 1ffff", as); end
  endtask

  task automatic test_random_ops(input int n);
    logic [16:0] pool [6];
    logic [7:0] rd, ds, wd; logic [16:0] as, addr; logic we;
    int ack_at, we_lo, oe_lo, drv, acks, bl;
    for (int i = 0; i < 6; i++) pool[i] = 17'($urandom);
    for (int i = 0; i < n; i++) begin
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 17'($urandom);
      wd   = 8'($urandom);
      do_op(we, addr, wd, $urandom_range(0, 3), rd, ack_at, we_lo, oe_lo, as, ds, drv, acks, bl);
      checks++; if (ack_at !== WC + 2) begin fails++; $display("FAIL rnd_ack_cycle[%0d]: got %0d, required %0d", i, ack_at, WC + 2); end
      checks++; if (acks !== 1) begin fails++; $display("FAIL rnd_ack_count[%0d]: got %0d, required 1", i, acks); end
      checks++; if (as !== addr) begin fails++; $display("FAIL rnd_addr[%0d]: got %h, required %h", i, as, addr); end
      checks++;
      if ({we_lo, oe_lo} !== (we ? {WC, 0} : {0, WC})) begin
        fails++; $display("FAIL rnd_strobes[%0d]: got we %0d oe %0d, required we=%b op of %0d cycles", i, we_lo, oe_lo, we, WC);
      end
      checks++;
      if (we) begin
        exp_mem[addr] = wd;
        if (ds !== wd) begin fails++; $display("FAIL rnd_wdata[%0d]: got %h, required %h", i, ds, wd); end
      end else if (rd !== ref_rd(addr)) begin
        fails++; $display("FAIL rnd_rdata[%0d]: got %h, required %h", i, rd, ref_rd(addr));
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  task automatic test_implicit;
    logic [7:0] rd, ds; logic [16:0] as, addr; logic ok;
    int ack_at, we_lo, oe_lo, drv, acks, bl;
    hold = 1'b0;
    wait_held(1'b0, 5, ok);
    man_ak = 1'b1;
    repeat (4) @(negedge clock);
    cpu_auto = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = (i == 0) ? 17'h00082 : 17'($urandom);
      do_op(1'b0, addr, 8'h00, $urandom_range(0, 2), rd, ack_at, we_lo, oe_lo, as, ds, drv, acks, bl);
      checks++; if (rd !== ref_rd(addr)) begin fails++; $display("FAIL imp_rdata[%0d]: got %h, required %h", i, rd, ref_rd(addr)); end
      checks++; if (ack_at <= WC + 2 || ack_at > 40) begin fails++; $display("FAIL imp_ack[%0d]: got cycle %0d, required %0d..40", i, ack_at, WC + 3); end
      checks++; if (bl < ack_at) begin fails++; $display("FAIL imp_busrq_low[%0d]: got %0d low cycles, required >= %0d", i, bl, ack_at); end
      checks++; if ({busrq_n, held} !== 2'b10) begin fails++; $display("FAIL imp_release[%0d]: got busrq_n/held %b, required 10", i, {busrq_n, held}); end
      repeat (10) @(negedge clock);
    end
    hold = 1'b1;
    @(negedge clock);
    checks++; if (busrq_n !== 1'b0) begin fails++; $display("FAIL imp_back_to_idle: got %b, required 0", busrq_n); end
    wait_held(1'b1, 15, ok);
    hold = 1'b0;
    wait_held(1'b0, 5, ok);
    repeat (10) @(negedge clock);
    cpu_auto = 1'b0; man_ak = 1'b1;
  endtask

  task automatic test_timeout;
    int err_at, bus_lo, strobe_lo, bus_lo_after;
    logic ack_with, rq_at_err, stayed, ok;
    err_at = -1; bus_lo = 0; strobe_lo = 0; bus_lo_after = 0; ack_with = 1'b0; rq_at_err = 1'b0;
    mon_we = 1'b0; mon_addr = 17'($urandom); mon_req = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (!busrq_n) begin bus_lo++; if (err_at >= 0) bus_lo_after++; end
      if (!sram_ce_n || !sram_oe_n || !sram_we_n) strobe_lo++;
      if (mon_err && err_at < 0) begin err_at = k; ack_with = mon_ack; rq_at_err = busrq_n; end
      if (err_at >= 0 && k == err_at + 10) break;
    end
    checks++; if (err_at !== GT + 1) begin fails++; $display("FAIL to_err_cycle: got %0d, required %0d", err_at, GT + 1); end
    checks++; if (ack_with !== 1'b1) begin fails++; $display("FAIL to_ack_with_err: got %b, required 1", ack_with); end
    checks++; if (rq_at_err !== 1'b1) begin fails++; $display("FAIL to_busrq_release: got %b, required 1", rq_at_err); end
    checks++; if (bus_lo !== GT) begin fails++; $display("FAIL to_busrq_len: got %0d, required %0d", bus_lo, GT); end
    checks++; if (strobe_lo !== 0) begin fails++; $display("FAIL to_no_strobe: got %0d cycles, required 0", strobe_lo); end
    checks++; if (bus_lo_after !== 0) begin fails++; $display("FAIL to_blocked_req: got %0d low cycles, required 0", bus_lo_after); end
    mon_req = 1'b0; hold = 1'b1;
    stayed = 1'b1;
    repeat (5) begin @(negedge clock); if (busrq_n !== 1'b1) stayed = 1'b0; end
    checks++; if (stayed !== 1'b1) begin fails++; $display("FAIL to_blocked_hold: got busrq_n low, required 1"); end
    hold = 1'b0;
    @(negedge clock);
    hold = 1'b1;
    @(negedge clock);
    checks++; if (busrq_n !== 1'b0) begin fails++; $display("FAIL to_unblock: got %b, required 0", busrq_n); end
    man_ak = 1'b0;
    wait_held(1'b1, 10, ok);
  endtask

  task automatic test_reset_mid_op;
    logic seen;
    seen = 1'b0;
    mon_we = 1'b1; mon_addr = 17'h00100; mon_wdata = 8'hC3; mon_req = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (!sram_we_n) seen = 1'b1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL rst_mid_setup: got no we_n pulse, required one"); end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({sram_we_n, sram_ce_n, busrq_n, sram_drive, held} !== 5'b11100) begin
      fails++; $display("FAIL rst_mid_async: got we/ce/busrq/drive/held %b, required 11100",
                        {sram_we_n, sram_ce_n, busrq_n, sram_drive, held});
    end
    mon_req = 1'b0; hold = 1'b0; man_ak = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busrq_n, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, held, mon_ack, mon_err} !== 8'b11110000) begin
      fails++; $display("FAIL rst_mid_after_ctrl: got %b, required 11110000",
                        {busrq_n, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, held, mon_ack, mon_err});
    end
    checks++;
    if ({sram_addr, sram_dout, mon_rdata} !== 33'd0) begin
      fails++; $display("FAIL rst_mid_after_data: got addr %h dout %h rdata %h, required 0", sram_addr, sram_dout, mon_rdata);
    end
    hold = 1'b1;
    @(negedge clock);
    checks++; if (busrq_n !== 1'b0) begin fails++; $display("FAIL rst_mid_idle: got %b, required 0", busrq_n); end
  endtask

  initial begin
    test_reset;
    mon_en = 1'b1;
    test_halt_go;
    test_write;
    test_read;
    test_random_ops(40);
    test_implicit;
    test_timeout;
    test_reset_mid_op;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
